// File: rtl/ifetch_bus_ctrl.sv
// rtl/ifetch_bus_ctrl.sv - instruction fetch bus responder for the multicycle pc
// Sequences FETCH/EXEC/HALT, runs the Avalon-style read and latches the instruction word.
module ifetch_bus_ctrl #(
   parameter bit          SWAP_BYTES = 1'b0,
   parameter int unsigned TIMEOUT    = 1024
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] addr,
   input  logic        finish,
   input  logic        data_stall,
   input  logic        waitrequest,
   input  logic [31:0] readdata,
   output logic [31:0] instr_address,
   output logic        instr_read,
   output logic [31:0] instruction_word,
   output logic        state,
   output logic        stall,
   output logic        halted,
   output logic        fetch_err
);

   typedef enum logic [1:0] {
      S_FETCH = 2'd0,
      S_EXEC  = 2'd1,
      S_HALT  = 2'd2
   } fsm_e;

   localparam logic [15:0] TIMEOUT_W = 16'(TIMEOUT);

   fsm_e        state_q, state_d;
   logic [15:0] wait_cnt_q, wait_cnt_d;
   logic [31:0] iword_q, iword_d;
   logic        err_q, err_d;

   logic        aligned;
   logic        timeout_hit;
   logic [31:0] rdata_sw;

   assign aligned       = (addr[1:0] == 2'b00);
   assign instr_address = {addr[31:2], 2'b00};

   // The edge that would record the TIMEOUT-th wait cycle is the one that gives up.
   assign timeout_hit = (TIMEOUT_W != 16'd0) && ((wait_cnt_q + 16'd1) == TIMEOUT_W);

   always_comb begin
      if (SWAP_BYTES) begin
         rdata_sw = {readdata[7:0], readdata[15:8], readdata[23:16], readdata[31:24]};
      end else begin
         rdata_sw = readdata;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_FETCH;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wait_cnt_q <= 16'd0;
         iword_q    <= 32'd0;
         err_q      <= 1'b0;
      end else begin
         wait_cnt_q <= wait_cnt_d;
         iword_q    <= iword_d;
         err_q      <= err_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      wait_cnt_d = wait_cnt_q;
      iword_d    = iword_q;
      err_d      = err_q;
      case (state_q)
         S_FETCH: begin
            if (!aligned) begin
               err_d   = 1'b1;
               state_d = S_HALT;
            end else if (!waitrequest) begin
               iword_d    = rdata_sw;
               wait_cnt_d = 16'd0;
               state_d    = S_EXEC;
            end else begin
               wait_cnt_d = wait_cnt_q + 16'd1;
               if (timeout_hit) begin
                  err_d   = 1'b1;
                  state_d = S_HALT;
               end
            end
         end
         S_EXEC: begin
            if (!data_stall) begin
               state_d = finish ? S_HALT : S_FETCH;
            end
         end
         default: state_d = S_HALT;
      endcase
   end

   // Read strobe is gated by reset so an abandoned transaction drops at once.
   always_comb begin
      instr_read = 1'b0;
      stall      = 1'b0;
      state      = 1'b0;
      halted     = 1'b0;
      case (state_q)
         S_FETCH: begin
            instr_read = aligned && !reset;
            stall      = aligned && !reset && waitrequest;
         end
         S_EXEC: begin
            state = 1'b1;
            stall = data_stall;
         end
         default: halted = 1'b1;
      endcase
   end

   assign instruction_word = iword_q;
   assign fetch_err        = err_q;

endmodule

// File: tb/tb_ifetch_bus_ctrl.sv
// tb/tb_ifetch_bus_ctrl.sv - directed vector bench for ifetch_bus_ctrl
module tb_ifetch_bus_ctrl;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] addr = 32'h10;
   logic        finish = 1'b0;
   logic        data_stall = 1'b0;
   logic        waitrequest = 1'b0;
   logic [31:0] readdata = 32'h0;

   logic [31:0] o0_addr, o0_iw, o1_addr, o1_iw;
   logic        o0_read, o0_state, o0_stall, o0_halt, o0_err;
   logic        o1_read, o1_state, o1_stall, o1_halt, o1_err;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   ifetch_bus_ctrl dut0 (
      .clk(clk), .reset(reset), .addr(addr), .finish(finish),
      .data_stall(data_stall), .waitrequest(waitrequest), .readdata(readdata),
      .instr_address(o0_addr), .instr_read(o0_read), .instruction_word(o0_iw),
      .state(o0_state), .stall(o0_stall), .halted(o0_halt), .fetch_err(o0_err)
   );

   ifetch_bus_ctrl #(.SWAP_BYTES(1'b1), .TIMEOUT(4)) dut1 (
      .clk(clk), .reset(reset), .addr(addr), .finish(finish),
      .data_stall(data_stall), .waitrequest(waitrequest), .readdata(readdata),
      .instr_address(o1_addr), .instr_read(o1_read), .instruction_word(o1_iw),
      .state(o1_state), .stall(o1_stall), .halted(o1_halt), .fetch_err(o1_err)
   );

   typedef struct {
      logic        rst;
      logic [31:0] addr;
      logic        fin;
      logic        ds;
      logic        wr;
      logic [31:0] rd;
      logic        e_state;
      logic        e_stall;
      logic        e_read;
      logic        e_halt;
      logic        e_err;
      logic [31:0] e_iw;
   } vec_t;

   vec_t tbl[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      // rst addr fin ds wr rd | state stall read halt err iw
      tbl.push_back('{1'b1, 32'h10, 1'b0, 1'b0, 1'b0, 32'h0060000b, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0});
      tbl.push_back('{1'b0, 32'h10, 1'b0, 1'b0, 1'b0, 32'h0060000b, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0});
      tbl.push_back('{1'b0, 32'h10, 1'b0, 1'b0, 1'b0, 32'h0060000b, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0060000b});
      tbl.push_back('{1'b0, 32'h10, 1'b0, 1'b0, 1'b0, 32'h0060000b, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0060000b});
      tbl.push_back('{1'b0, 32'h10, 1'b0, 1'b0, 1'b0, 32'h0060000b, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0060000b});
      tbl.push_back('{1'b0, 32'h10, 1'b0, 1'b0, 1'b1, 32'hdeadbeef, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0060000b});
      tbl.push_back('{1'b0, 32'h10, 1'b0, 1'b0, 1'b1, 32'hdeadbeef, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0060000b});
      tbl.push_back('{1'b0, 32'h10, 1'b1, 1'b0, 1'b1, 32'hdeadbeef, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0060000b});
      tbl.push_back('{1'b0, 32'h10, 1'b1, 1'b1, 1'b0, 32'h04000002, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0060000b});
      tbl.push_back('{1'b0, 32'h10, 1'b1, 1'b1, 1'b0, 32'h04000002, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h04000002});
      tbl.push_back('{1'b0, 32'h10, 1'b1, 1'b1, 1'b0, 32'h04000002, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h04000002});
      tbl.push_back('{1'b0, 32'h10, 1'b1, 1'b0, 1'b1, 32'h04000002, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h04000002});
      tbl.push_back('{1'b0, 32'h10, 1'b0, 1'b0, 1'b1, 32'h04000002, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h04000002});
      tbl.push_back('{1'b0, 32'h10, 1'b0, 1'b0, 1'b0, 32'h04000002, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h04000002});
      tbl.push_back('{1'b1, 32'h10, 1'b0, 1'b0, 1'b0, 32'h04000002, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0});
      tbl.push_back('{1'b0, 32'h12, 1'b0, 1'b0, 1'b0, 32'h04000002, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0});
      tbl.push_back('{1'b0, 32'h12, 1'b0, 1'b0, 1'b0, 32'h04000002, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0});
      tbl.push_back('{1'b0, 32'h12, 1'b0, 1'b0, 1'b0, 32'h04000002, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0});
      tbl.push_back('{1'b1, 32'h10, 1'b0, 1'b0, 1'b0, 32'h04000002, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0});
      tbl.push_back('{1'b0, 32'h10, 1'b0, 1'b0, 1'b0, 32'h04000002, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0});

      step();
      for (int i = 0; i < tbl.size(); i++) begin
         reset       = tbl[i].rst;
         addr        = tbl[i].addr;
         finish      = tbl[i].fin;
         data_stall  = tbl[i].ds;
         waitrequest = tbl[i].wr;
         readdata    = tbl[i].rd;
         @(negedge clk);
         chk($sformatf("v%0d state", i), 32'(o0_state), 32'(tbl[i].e_state));
         chk($sformatf("v%0d stall", i), 32'(o0_stall), 32'(tbl[i].e_stall));
         chk($sformatf("v%0d instr_read", i), 32'(o0_read), 32'(tbl[i].e_read));
         chk($sformatf("v%0d halted", i), 32'(o0_halt), 32'(tbl[i].e_halt));
         chk($sformatf("v%0d fetch_err", i), 32'(o0_err), 32'(tbl[i].e_err));
         chk($sformatf("v%0d instruction_word", i), o0_iw, tbl[i].e_iw);
         chk($sformatf("v%0d instr_address", i), o0_addr, {tbl[i].addr[31:2], 2'b00});
         @(posedge clk);
         #1;
      end

      // Reset asserted between edges while a read is pending.
      reset = 1'b1; addr = 32'h10; waitrequest = 1'b0; readdata = 32'h11223344;
      finish = 1'b0; data_stall = 1'b0;
      step();
      reset = 1'b0;
      step();
      waitrequest = 1'b1;
      step();
      #1;
      chk("midwait pre read", 32'(o0_read), 32'd1);
      chk("midwait pre iw", o0_iw, 32'h11223344);
      @(negedge clk);
      #2;
      reset = 1'b1;
      #1;
      chk("midwait rst read", 32'(o0_read), 32'd0);
      chk("midwait rst state", 32'(o0_state), 32'd0);
      chk("midwait rst stall", 32'(o0_stall), 32'd0);
      chk("midwait rst iw", o0_iw, 32'h0);
      step();
      reset = 1'b0;
      #1;
      chk("post reset read", 32'(o0_read), 32'd1);

      // Swap plus timeout with counter cleared between fetches (dut1: TIMEOUT=4).
      reset = 1'b1; waitrequest = 1'b1; readdata = 32'h0b006000;
      step();
      reset = 1'b0;
      repeat (3) step();
      #1;
      chk("to first 3 waits err", 32'(o1_err), 32'd0);
      chk("to first 3 waits read", 32'(o1_read), 32'd1);
      waitrequest = 1'b0;
      step();
      #1;
      chk("swap state", 32'(o1_state), 32'd1);
      chk("swap iw", o1_iw, 32'h0060000b);
      chk("noswap iw", o0_iw, 32'h0b006000);
      waitrequest = 1'b1;
      step();
      repeat (3) step();
      #1;
      chk("to 3 waits err", 32'(o1_err), 32'd0);
      chk("to 3 waits stall", 32'(o1_stall), 32'd1);
      step();
      #1;
      chk("to 4 waits err", 32'(o1_err), 32'd1);
      chk("to 4 waits halted", 32'(o1_halt), 32'd1);
      chk("to 4 waits read", 32'(o1_read), 32'd0);
      chk("default timeout err", 32'(o0_err), 32'd0);
      chk("default timeout read", 32'(o0_read), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
